// File: rtl/pwm_phase_ctrl.sv
// Phase/duty sequencer for a bank of PWM channels: shadow/active banks, master counter and realignment FSM.
// Optional readback of the active bank is enabled with `define PWM_PHASE_CTRL_RDBK_EN.
module pwm_phase_ctrl #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CW     = 11,
  parameter int unsigned PERIOD = 1250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_ch,
  input  logic [CW-1:0]        wr_phase,
  input  logic [CW-1:0]        wr_duty,
  output logic                 wr_err,
  input  logic                 commit,
  output logic                 busy,
  output logic                 frame_start,
  output logic [NUM_CH-1:0]    pwm_rst,
  output logic [NUM_CH*CW-1:0] pwm_compare
`ifdef PWM_PHASE_CTRL_RDBK_EN
  ,
  input  logic [7:0]           rd_ch,
  output logic [CW-1:0]        rd_phase,
  output logic [CW-1:0]        rd_duty
`endif
);

  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] PER_V    = CW'(PERIOD);
  localparam logic [CW-1:0] DUTY_MAX = CW'(PERIOD + 1);
  localparam logic [7:0]    NUM_CH_V = 8'(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT_WRAP, ALIGN, RUN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        ctr;
  logic [CW-1:0]        sh_phase [NUM_CH];
  logic [CW-1:0]        sh_duty  [NUM_CH];
  logic [CW-1:0]        sh_phase_nxt [NUM_CH];
  logic [CW-1:0]        sh_duty_nxt  [NUM_CH];
  logic [CW-1:0]        act_phase [NUM_CH];
  logic [CW-1:0]        act_duty  [NUM_CH];
  logic [NUM_CH-1:0]    rst_nxt;
  logic [NUM_CH*CW-1:0] cmp_nxt;
  logic [CH_W-1:0]      wr_idx;
  logic                 wr_fire, wr_in_range, at_wrap, copy;

  assign wr_ready    = (state == IDLE) || (state == RUN);
  assign busy        = (state == WAIT_WRAP) || (state == ALIGN);
  assign frame_start = (ctr == '0);
  assign at_wrap     = (ctr == PER_V);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_ch < NUM_CH_V);
  assign wr_idx      = wr_ch[CH_W-1:0];

  // Master period counter, free-running outside reset
  always_ff @(posedge clk) begin
    if (rst) ctr <= '0;
    else     ctr <= at_wrap ? '0 : ctr + CW'(1);
  end

  // Shadow bank after this cycle's write, so a same-cycle commit copies it
  always_comb begin
    sh_phase_nxt = sh_phase;
    sh_duty_nxt  = sh_duty;
    if (wr_fire && wr_in_range) begin
      sh_phase_nxt[wr_idx] = (wr_phase > PER_V)    ? PER_V    : wr_phase;
      sh_duty_nxt[wr_idx]  = (wr_duty  > DUTY_MAX) ? DUTY_MAX : wr_duty;
    end
  end

  // Next state and next per-channel reset/compare
  always_comb begin
    state_nxt = state;
    rst_nxt   = pwm_rst;
    copy      = 1'b0;
    cmp_nxt   = '0;
    case (state)
      IDLE: begin
        rst_nxt = '1;
        if (commit) state_nxt = WAIT_WRAP;
      end
      WAIT_WRAP: state_nxt = WAIT_WRAP;
      ALIGN: begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (ctr == act_phase[i]) rst_nxt[i] = 1'b0;
        if (at_wrap) begin
          rst_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        rst_nxt = '0;
        if (commit) state_nxt = WAIT_WRAP;
      end
      default: state_nxt = IDLE;
    endcase
    // A pending commit lands at the wrap, including one raised in the wrap cycle itself
    if (state_nxt == WAIT_WRAP && at_wrap) begin
      copy      = 1'b1;
      rst_nxt   = '1;
      state_nxt = ALIGN;
    end
    if (!en) begin
      copy      = 1'b0;
      rst_nxt   = '1;
      state_nxt = IDLE;
    end
    // A copy always holds every channel, so the old active duty is safe to use here
    for (int unsigned i = 0; i < NUM_CH; i++)
      cmp_nxt[i*CW +: CW] = rst_nxt[i] ? '0 : act_duty[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pwm_rst     <= '1;
      pwm_compare <= '0;
      wr_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sh_phase[i]  <= '0;
        sh_duty[i]   <= '0;
        act_phase[i] <= '0;
        act_duty[i]  <= '0;
      end
    end else begin
      state       <= state_nxt;
      pwm_rst     <= rst_nxt;
      pwm_compare <= cmp_nxt;
      wr_err      <= wr_fire && !wr_in_range;
      sh_phase    <= sh_phase_nxt;
      sh_duty     <= sh_duty_nxt;
      if (copy) begin
        act_phase <= sh_phase_nxt;
        act_duty  <= sh_duty_nxt;
      end
    end
  end

`ifdef PWM_PHASE_CTRL_RDBK_EN
  // Active-bank readback, out-of-range channels read as zero
  always_ff @(posedge clk) begin
    if (rst || !(rd_ch < NUM_CH_V)) begin
      rd_phase <= '0;
      rd_duty  <= '0;
    end else begin
      rd_phase <= act_phase[rd_ch[CH_W-1:0]];
      rd_duty  <= act_duty[rd_ch[CH_W-1:0]];
    end
  end
`endif

endmodule
